// File: rtl/key_pio_pkg.sv
// Shared constants for the key_input_pio Avalon-MM input PIO: register
// addresses, edge-type encodings and the per-bit edge selection helper.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_event(input logic cur, input logic prev, input int edge_type);
        logic rise;
        logic fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (edge_type)
            EDGE_RISE: edge_event = rise;
            EDGE_FALL: edge_event = fall;
            default:   edge_event = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/key_pio_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-cycle debounce filter.
// The counter exists only when KEY_PIO_DEBOUNCE_EN is defined; otherwise the
// debounced value simply follows the synchroniser output one cycle later.
module key_pio_debounce
    import key_pio_pkg::*;
#(
    parameter logic IDLE_BIT        = 1'b1,
    parameter int   DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic deb
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("key_pio_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;
    logic deb_q, deb_d;

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sync0_d = in_bit;
        sync1_d = sync0_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        // Any return to the settled value restarts the stability window.
        if (sync1_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = sync1_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= IDLE_BIT;
            sync1_q <= IDLE_BIT;
            deb_q   <= IDLE_BIT;
            cnt_q   <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        sync0_d = in_bit;
        sync1_d = sync0_q;
        deb_d   = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= IDLE_BIT;
            sync1_q <= IDLE_BIT;
            deb_q   <= IDLE_BIT;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            deb_q   <= deb_d;
        end
    end
`endif

    assign deb = deb_q;

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM input PIO for pushbuttons/switches: synchronise, debounce
// (KEY_PIO_DEBOUNCE_EN), capture edges, and raise a maskable level irq.
module key_input_pio
    import key_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = WIDTH'(4'hF),
    parameter int               EDGE_TYPE       = EDGE_FALL,
    parameter int               DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("key_input_pio: WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] deb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        key_pio_debounce #(
            .IDLE_BIT        (IDLE_LEVEL[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .deb     (deb[i])
        );
    end

    logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic [WIDTH-1:0] evt;
    logic             unused_wdata;

    // Only the low WIDTH write-data bits are architected.
    assign unused_wdata = ^writedata;

    always_comb begin
        wr_en      = chipselect & ~write_n;
        deb_dly_d  = deb;
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        readdata_d = '0;
        evt        = '0;

        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = edge_event(deb[i], deb_dly_q[i], EDGE_TYPE);
        end

        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // Set is applied after the clear so a coincident event is never lost.
        edgecap_d = edgecap_d | evt;

        irq_d = |(edgecap_q & irqmask_q);

        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_dly_q  <= IDLE_LEVEL;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_dly_q  <= deb_dly_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_key_input_pio.sv
// Self-checking bench for key_input_pio (WIDTH=4, falling edge, DEBOUNCE_CYCLES=4);
// latencies follow KEY_PIO_DEBOUNCE_EN so both builds are exercised.
module tb_key_input_pio;
    import key_pio_pkg::*;

    localparam int DB = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int EFF = DB;
`else
    localparam int EFF = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    key_input_pio #(
        .WIDTH           (4),
        .IDLE_LEVEL      (4'hF),
        .EDGE_TYPE       (EDGE_FALL),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[14];
    int   glens[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        tick(1);
        chipselect = 1'b0;
        d          = readdata;
    endtask

    logic [31:0] rd;

    initial begin
        vecs[0]  = '{1'b0, ADDR_DATA,    32'h0,        32'h0000_000F, 1'b0};
        vecs[1]  = '{1'b0, 2'd1,         32'h0,        32'h0,         1'b0};
        vecs[2]  = '{1'b0, ADDR_EDGECAP, 32'h0,        32'h0,         1'b0};
        vecs[3]  = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h0,         1'b0};
        vecs[4]  = '{1'b1, ADDR_IRQMASK, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h0000_000F, 1'b0};
        vecs[6]  = '{1'b1, ADDR_DATA,    32'h0,        32'h0,         1'b0};
        vecs[7]  = '{1'b0, ADDR_DATA,    32'h0,        32'h0000_000F, 1'b0};
        vecs[8]  = '{1'b1, 2'd1,         32'h1234_5678, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 2'd1,         32'h0,        32'h0,         1'b0};
        vecs[10] = '{1'b1, ADDR_EDGECAP, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, ADDR_EDGECAP, 32'h0,        32'h0,         1'b0};
        vecs[12] = '{1'b1, ADDR_IRQMASK, 32'h0,        32'h0,         1'b0};
        vecs[13] = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h0,         1'b0};
        glens    = '{1, 3, 4};

        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        tick(3);

        // Register-access vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                bus_wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_rd(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Clean press of key 1 with irqmask = 0x2
        bus_wr(ADDR_IRQMASK, 32'h2);
        address = ADDR_DATA;
        in_port = 4'hD;
        tick(EFF + 2);
        check("press_data_before", readdata, 32'hF);
        tick(1);
        check("press_data_after", readdata, 32'hD);
        check("press_irq_before", {31'h0, irq}, 32'h0);
        tick(1);
        check("press_irq_after", {31'h0, irq}, 32'h1);
        bus_rd(ADDR_EDGECAP, rd);
        check("press_edgecap", rd, 32'h2);
        bus_wr(ADDR_EDGECAP, 32'h2);
        tick(1);
        check("press_irq_cleared", {31'h0, irq}, 32'h0);
        in_port = 4'hF;
        tick(EFF + 4);
        bus_rd(ADDR_EDGECAP, rd);
        check("release_no_capture", rd, 32'h0);
        bus_rd(ADDR_DATA, rd);
        check("release_data", rd, 32'hF);
        bus_wr(ADDR_IRQMASK, 32'h0);

        // Glitches on key 2; the last one leaves edgecapture = 0x4
        for (int g = 0; g < 3; g++) begin
            in_port = 4'hB;
            tick(glens[g]);
            in_port = 4'hF;
            tick(EFF + 4);
            bus_rd(ADDR_DATA, rd);
            check($sformatf("glitch%0d_data", glens[g]), rd, 32'hF);
            bus_rd(ADDR_EDGECAP, rd);
            check($sformatf("glitch%0d_edgecap", glens[g]), rd, (glens[g] >= EFF) ? 32'h4 : 32'h0);
            if (g < 2) bus_wr(ADDR_EDGECAP, 32'hF);
        end

        // Mask gating
        tick(1);
        check("mask_off_irq", {31'h0, irq}, 32'h0);
        bus_wr(ADDR_IRQMASK, 32'h4);
        check("mask_write_cycle_irq", {31'h0, irq}, 32'h0);
        tick(1);
        check("mask_on_irq", {31'h0, irq}, 32'h1);
        bus_rd(ADDR_EDGECAP, rd);
        check("mask_keeps_edgecap", rd, 32'h4);
        bus_rd(ADDR_IRQMASK, rd);
        check("mask_readback", rd, 32'h4);
        bus_wr(ADDR_EDGECAP, 32'h4);
        tick(1);
        check("mask_clear_irq", {31'h0, irq}, 32'h0);
        bus_wr(ADDR_IRQMASK, 32'h0);

        // W1C on a two-bit capture
        in_port = 4'hC;
        tick(EFF + 4);
        in_port = 4'hF;
        tick(EFF + 4);
        bus_rd(ADDR_EDGECAP, rd);
        check("w1c_both", rd, 32'h3);
        bus_wr(ADDR_EDGECAP, 32'h1);
        bus_rd(ADDR_EDGECAP, rd);
        check("w1c_bit0", rd, 32'h2);

        // Clear of bit 1 lands on the same edge as a new bit-1 event
        in_port = 4'hD;
        tick(EFF + 2);
        bus_wr(ADDR_EDGECAP, 32'h2);
        bus_rd(ADDR_EDGECAP, rd);
        check("collision_set_wins", rd, 32'h2);
        in_port = 4'hF;
        tick(EFF + 4);
        bus_wr(ADDR_EDGECAP, 32'h2);
        bus_rd(ADDR_EDGECAP, rd);
        check("collision_then_clear", rd, 32'h0);

        // Mid-operation reset
        in_port = 4'hE;
        tick(EFF + 4);
        bus_rd(ADDR_EDGECAP, rd);
        check("pre_reset_edgecap", rd, 32'h1);
        bus_wr(ADDR_IRQMASK, 32'h1);
        tick(2);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        reset_n = 1'b0;
        in_port = 4'hF;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'h0, irq}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(EFF + 4);
        bus_rd(ADDR_EDGECAP, rd);
        check("post_reset_edgecap", rd, 32'h0);
        bus_rd(ADDR_IRQMASK, rd);
        check("post_reset_mask", rd, 32'h0);
        bus_rd(ADDR_DATA, rd);
        check("post_reset_data", rd, 32'hF);
        check("post_reset_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
